inst_memory_responder: RTL and testbench
========================================

INST_MEMORY_RESPONDER -- requirements
Module: inst_memory_responder

Interface
REQ-001 Parameter READ_LATENCY, default 4, SHALL set the clock cycles from read acceptance to data valid; legal range 1..255.
REQ-002 Parameter INIT_FILE, default "" (empty), SHALL name an optional hex image preloaded into storage at elaboration.
REQ-003 clock  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 mem_read  input  1  SHALL be the block-read request from the instruction cache, held high until the transfer completes.
REQ-006 mem_address  input  6  SHALL be the block address (64 blocks of 16 bytes).
REQ-007 mem_readdata  output  128  SHALL be the returned block (four 32-bit instructions).
REQ-008 mem_busywait  output  1  SHALL be high while a requested block is not yet available.
REQ-009 prog_we  input  1  SHALL be the byte-write strobe for program loading.
REQ-010 prog_addr  input  10  SHALL be the byte address for program loading.
REQ-011 prog_data  input  8  SHALL be the byte to write.

Function
REQ-012 Storage SHALL be 1024 bytes; block b SHALL occupy bytes 16b..16b+15; byte 16b+k SHALL map to mem_readdata[8k+7:8k] (little-endian, word 0 in [31:0]).
REQ-013 FSM states SHALL be IDLE, READ, DONE.
REQ-014 IDLE: on mem_read=1, the block SHALL latch mem_address, load the latency counter with READ_LATENCY-1, and enter READ.
REQ-015 READ: the counter SHALL decrement each cycle; at count 0 the block SHALL register the addressed 128-bit block into mem_readdata and enter DONE.
REQ-016 mem_busywait SHALL be combinational: 1 when mem_read=1 and state is not DONE, or when state is DONE and mem_address differs from the latched address; else 0.
REQ-017 Consequently mem_busywait SHALL rise in the same cycle mem_read rises, so a requester sampling at the next edge never sees a false ready.
REQ-018 DONE: with mem_read=1 and unchanged address, the block SHALL hold mem_readdata and remain in DONE.
REQ-019 DONE: with mem_read=0, the block SHALL return to IDLE; mem_readdata SHALL hold its last value.
REQ-020 DONE: with mem_read=1 and a changed address, the block SHALL relatch and restart READ (full latency).
REQ-021 READ: if mem_read falls, the transfer SHALL abort to IDLE without updating mem_readdata.
REQ-022 READ: a change of mem_address SHALL be ignored; the latched address governs the transfer.
REQ-023 prog_we=1 SHALL write prog_data to byte prog_addr at the clock edge, in any state.
REQ-024 A prog_we write to the block being read SHALL be visible in the returned data if it occurs at or before the edge on which the data is registered.
REQ-025 Total latency: mem_read rising before edge E SHALL give mem_busywait=0 with valid data after edge E+READ_LATENCY.

Reset
REQ-026 reset=0 SHALL force state IDLE, counter 0, latched address 0, and mem_readdata 0, immediately and independent of clock.
REQ-027 Storage contents SHALL NOT be altered by reset.
REQ-028 A reset during READ SHALL abort the transfer; after release, a still-high mem_read SHALL start a fresh full-latency read.

Structure
REQ-029 A shared package/header SHALL hold BLOCK_BITS=128, BLOCK_ADDR_W=6, BYTE_ADDR_W=10, and the state encodings.
REQ-030 The latency down-counter SHALL be one sub-module, mem_latency_counter (load, decrement, zero flag).

Verification
REQ-031 Load bytes 0x00..0x0F at addresses 0x000..0x00F, with READ_LATENCY=4 and mem_address=0 -> mem_busywait high for exactly 4 edges, then mem_readdata=0x0F0E..0100.
REQ-032 Read block 5, then block 6 with mem_read held high and the address changed in DONE -> busywait reasserts in the same cycle; block 6 is returned after 4 more edges.
REQ-033 Drop mem_read after 2 READ cycles -> state IDLE, mem_readdata unchanged, busywait 0.
REQ-034 Assert reset for 1 ns mid-READ with mem_read high -> mem_readdata=0 immediately; a new read completes 4 edges after release; stored bytes are intact.
REQ-035 prog_we writes byte 0x3F=0xAA while block 3 is in READ -> the returned block has 0xAA in bits [127:120].
REQ-036 READ_LATENCY=1, back-to-back reads of blocks 0 and 63 -> each returns after 1 edge; block 63 is taken from bytes 0x3F0..0x3FF.

Source files
------------

// File: rtl/inst_memory_responder_pkg.sv
// Shared widths, FSM encoding and program-write payload for the instruction memory responder.
package inst_memory_responder_pkg;

  localparam int unsigned BLOCK_BITS      = 128;
  localparam int unsigned BLOCK_ADDR_W    = 6;
  localparam int unsigned BYTE_ADDR_W     = 10;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned BYTES_PER_BLOCK = BLOCK_BITS / BYTE_W;
  localparam int unsigned OFFSET_W        = BYTE_ADDR_W - BLOCK_ADDR_W;
  localparam int unsigned MEM_BYTES       = 1 << BYTE_ADDR_W;
  localparam int unsigned LAT_W           = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic                   we;
    logic [BYTE_ADDR_W-1:0] addr;
    logic [BYTE_W-1:0]      data;
  } prog_wr_t;

  // Overlay a same-edge program write onto a block read from storage.
  function automatic logic [BLOCK_BITS-1:0] forward_write(
    input logic [BLOCK_BITS-1:0]   blk,
    input logic [BLOCK_ADDR_W-1:0] blk_addr,
    input prog_wr_t                wr
  );
    logic [BLOCK_BITS-1:0] r;
    r = blk;
    if (wr.we && (wr.addr[BYTE_ADDR_W-1:OFFSET_W] == blk_addr)) begin
      r[{wr.addr[OFFSET_W-1:0], 3'b000} +: BYTE_W] = wr.data;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Read-latency down-counter: load, decrement and a zero flag.
module mem_latency_counter
  import inst_memory_responder_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [LAT_W-1:0] load_value,
  output logic             zero_c
);

  logic [LAT_W-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - LAT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/inst_memory_responder.sv
// Byte-programmable 1 KiB instruction store answering 128-bit block reads
// after a fixed latency, with a combinational busy indication.
module inst_memory_responder
  import inst_memory_responder_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 4,
  parameter string       INIT_FILE    = ""
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_read,
  input  logic [BLOCK_ADDR_W-1:0] mem_address,
  output logic [BLOCK_BITS-1:0]   mem_readdata,
  output logic                    mem_busywait,
  input  logic                    prog_we,
  input  logic [BYTE_ADDR_W-1:0]  prog_addr,
  input  logic [BYTE_W-1:0]       prog_data
);

  localparam logic [LAT_W-1:0] LOAD_VALUE = LAT_W'(READ_LATENCY - 1);

  logic [BYTE_W-1:0] mem [MEM_BYTES];

  state_e                  state, next_state;
  logic [BLOCK_ADDR_W-1:0] lat_addr, next_addr;
  logic [BLOCK_BITS-1:0]   next_data;
  logic [BLOCK_BITS-1:0]   raw_block;
  logic [BLOCK_BITS-1:0]   fwd_block;
  logic                    cnt_load;
  logic                    cnt_dec;
  logic                    cnt_zero;
  prog_wr_t                prog_wr;

  assign prog_wr = '{we: prog_we, addr: prog_addr, data: prog_data};

  always_ff @(posedge clock) begin
    if (prog_wr.we) mem[prog_wr.addr] <= prog_wr.data;
  end

  // Gather the latched block, then let a same-edge write win over stale storage.
  always_comb begin
    raw_block = '0;
    for (int k = 0; k < BYTES_PER_BLOCK; k++) begin
      raw_block[k*BYTE_W +: BYTE_W] = mem[{lat_addr, OFFSET_W'(k)}];
    end
    fwd_block = forward_write(raw_block, lat_addr, prog_wr);
  end

  mem_latency_counter u_latency (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (LOAD_VALUE),
    .zero_c     (cnt_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      lat_addr     <= '0;
      mem_readdata <= '0;
    end else begin
      state        <= next_state;
      lat_addr     <= next_addr;
      mem_readdata <= next_data;
    end
  end

  always_comb begin
    next_state = state;
    next_addr  = lat_addr;
    next_data  = mem_readdata;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read) begin
          next_addr  = mem_address;
          cnt_load   = 1'b1;
          next_state = READ;
        end
      end
      READ: begin
        if (!mem_read) begin
          next_state = IDLE;
        end else if (cnt_zero) begin
          next_data  = fwd_block;
          next_state = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        if (!mem_read) begin
          next_state = IDLE;
        end else if (mem_address != lat_addr) begin
          next_addr  = mem_address;
          cnt_load   = 1'b1;
          next_state = READ;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Busy must rise in the request cycle so the cache never samples a stale ready.
  assign mem_busywait = (mem_read && (state != DONE)) ||
                        ((state == DONE) && (mem_address != lat_addr));

endmodule

// File: tb/tb_inst_memory_responder.sv
// Directed bench for inst_memory_responder: two lanes (latency 4 and 1), each
// with a transaction-level reference model checked every cycle.
module tb_inst_memory_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         prog_we;
  logic [9:0]   prog_addr;
  logic [7:0]   prog_data;
  logic         rd    [2];
  logic [5:0]   addr  [2];
  logic [127:0] rdata [2];
  logic         busy  [2];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    if (i < 16) return 8'(i);
    return 8'(i * 37 + 11);
  endfunction

  function automatic logic [127:0] pat_block(input int b);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = pat(16*b + k);
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned L = (g == 0) ? 4 : 1;

    inst_memory_responder #(.READ_LATENCY(L), .INIT_FILE("")) dut (
      .clock        (clock),
      .reset        (reset),
      .mem_read     (rd[g]),
      .mem_address  (addr[g]),
      .mem_readdata (rdata[g]),
      .mem_busywait (busy[g]),
      .prog_we      (prog_we),
      .prog_addr    (prog_addr),
      .prog_data    (prog_data)
    );

    logic [7:0]   mm [1024];
    logic         served;
    logic         active;
    int           remaining;
    logic [5:0]   req_addr;
    logic [127:0] exp_data;

    function automatic logic [127:0] block_of(input logic [5:0] b);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = mm[16*int'(b) + k];
      return r;
    endfunction

    // A request is served L edges after acceptance; a new address re-requests.
    always @(posedge clock or negedge reset) begin
      if (!reset) begin
        served = 1'b0; active = 1'b0; remaining = 0; req_addr = 6'd0; exp_data = '0;
      end else begin
        if (prog_we) mm[prog_addr] = prog_data;
        if (!rd[g]) begin
          active = 1'b0;
          served = 1'b0;
        end else if (active) begin
          remaining--;
          if (remaining == 0) begin
            exp_data = block_of(req_addr);
            active   = 1'b0;
            served   = 1'b1;
          end
        end else if (!served || addr[g] != req_addr) begin
          active    = 1'b1;
          served    = 1'b0;
          req_addr  = addr[g];
          remaining = int'(L);
        end
      end
    end

    always @(negedge clock) begin
      if (reset) begin
        check($sformatf("lane%0d busywait", g), {127'd0, busy[g]},
              {127'd0, (rd[g] && !served) || (served && addr[g] != req_addr)});
        check($sformatf("lane%0d readdata", g), rdata[g], exp_data);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Waits for the acceptance edge, then counts cycles with busy still high.
  task automatic count_busy(input int g, output int n);
    @(posedge clock);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!busy[g]) break;
      n++;
    end
  endtask

  int n;

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    rd[0] = 1'b0; rd[1] = 1'b0; addr[0] = '0; addr[1] = '0;
    #1 reset = 1'b0;
    #1;
    check("reset readdata0", rdata[0], 128'd0);
    check("reset readdata1", rdata[1], 128'd0);
    check("reset busy0", {127'd0, busy[0]}, 128'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;

    for (int i = 0; i < 1024; i++) begin
      prog_we = 1'b1; prog_addr = 10'(i); prog_data = pat(i);
      step(1);
    end
    prog_we = 1'b0;

    // Block 0 after a fresh program load
    rd[0] = 1'b1; addr[0] = 6'd0;
    #1 check("busy same cycle", {127'd0, busy[0]}, 128'd1);
    count_busy(0, n);
    check("latency blk0", 128'(n), 128'd4);
    check("blk0 literal", rdata[0], 128'h0F0E0D0C0B0A09080706050403020100);

    // Address changes in DONE with mem_read held
    step(1); addr[0] = 6'd5;
    #1 check("busy on addr5", {127'd0, busy[0]}, 128'd1);
    count_busy(0, n);
    check("latency blk5", 128'(n), 128'd4);
    check("blk5 data", rdata[0], pat_block(5));
    step(1); addr[0] = 6'd6;
    #1 check("busy on addr6", {127'd0, busy[0]}, 128'd1);
    count_busy(0, n);
    check("latency blk6", 128'(n), 128'd4);
    check("blk6 data", rdata[0], pat_block(6));

    // Abort after two READ cycles
    step(1); rd[0] = 1'b0;
    step(1); rd[0] = 1'b1; addr[0] = 6'd7;
    step(3); rd[0] = 1'b0;
    #1 check("abort busy", {127'd0, busy[0]}, 128'd0);
    step(3);
    check("abort keeps data", rdata[0], pat_block(6));
    check("abort idle busy", {127'd0, busy[0]}, 128'd0);

    // Address change during READ is ignored
    rd[0] = 1'b1; addr[0] = 6'd8;
    step(2); addr[0] = 6'd9;
    repeat (3) @(posedge clock);
    #1;
    check("latched addr governs", rdata[0], pat_block(8));
    check("busy addr differs in DONE", {127'd0, busy[0]}, 128'd1);
    #1 rd[0] = 1'b0;
    step(1);

    // Program write into block 3 while it is being read
    rd[0] = 1'b1; addr[0] = 6'd3;
    step(2);
    prog_we = 1'b1; prog_addr = 10'h03F; prog_data = 8'hAA;
    step(1); prog_we = 1'b0;
    repeat (2) @(posedge clock);
    #1 check("write during READ", {120'd0, rdata[0][127:120]}, 128'hAA);
    #1 rd[0] = 1'b0;
    step(1);

    // Program write on the very edge the block is registered
    rd[0] = 1'b1; addr[0] = 6'd4;
    step(4);
    prog_we = 1'b1; prog_addr = 10'h040; prog_data = 8'h55;
    step(1); prog_we = 1'b0;
    #1 check("write on data edge", {120'd0, rdata[0][7:0]}, 128'h55);
    #1 rd[0] = 1'b0;
    step(1);

    // Reset pulse in the middle of a read
    rd[0] = 1'b1; addr[0] = 6'd2;
    step(2);
    reset = 1'b0;
    #0.5 check("reset clears data", rdata[0], 128'd0);
    check("reset busy with read", {127'd0, busy[0]}, 128'd1);
    #0.5 reset = 1'b1;
    count_busy(0, n);
    check("latency after reset", 128'(n), 128'd4);
    check("bytes intact", rdata[0], pat_block(2));
    step(1); rd[0] = 1'b0;
    step(1);

    // Latency-1 lane: back-to-back blocks 0 and 63
    rd[1] = 1'b1; addr[1] = 6'd0;
    count_busy(1, n);
    check("lat1 blk0 latency", 128'(n), 128'd1);
    check("lat1 blk0 data", rdata[1], pat_block(0));
    step(1); addr[1] = 6'd63;
    #1 check("lat1 busy on 63", {127'd0, busy[1]}, 128'd1);
    count_busy(1, n);
    check("lat1 blk63 latency", 128'(n), 128'd1);
    check("lat1 blk63 data", rdata[1], pat_block(63));
    check("lat1 byte 0x3F0", {120'd0, rdata[1][7:0]}, 128'hBB);
    step(1); rd[1] = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
